// File: rtl/dbs_pkg.sv
// dbs_pkg: shared widths and FSM state type for the dbs sequential divider.
// Contents: DVD_W (dividend/quotient width), DVS_W (divisor/remainder width),
//           ITER (iterations per division), CNT_W (iteration counter width),
//           state_e (S_IDLE, S_RUN, S_DONE).
package dbs_pkg;

    localparam int unsigned DVD_W = 16;
    localparam int unsigned DVS_W = 8;
    localparam int unsigned ITER  = 16;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dbs_step.sv
// dbs_step: one combinational restoring-division iteration.
// Ports:
//   pr      in  [DVS_W-1:0] : current partial remainder
//   da_msb  in  1           : dividend bit being shifted in
//   db      in  [DVS_W-1:0] : divisor
//   pr_next out [DVS_W-1:0] : partial remainder after this step
//   q       out 1           : quotient bit produced by this step
module dbs_step
    import dbs_pkg::*;
(
    input  logic [DVS_W-1:0] pr,
    input  logic             da_msb,
    input  logic [DVS_W-1:0] db,
    output logic [DVS_W-1:0] pr_next,
    output logic             q
);

    logic [DVS_W:0] t;
    logic [DVS_W:0] db_ext;

    // 9-bit trial subtract; the remainder is restored when the trial fails.
    always_comb begin
        t       = {pr, da_msb};
        db_ext  = {1'b0, db};
        q       = (t >= db_ext);
        pr_next = q ? DVS_W'(t - db_ext) : t[DVS_W-1:0];
    end

endmodule

// File: rtl/dbs.sv
// dbs: sequential 16/8 restoring divider, one quotient bit per clock.
// Optional feature macro: DBS_DIVZERO_EN (divisor zero short-circuits to a
// one-cycle result with Err=1; when undefined Err is tied low and B==0 runs
// the full iteration sequence).
// Ports:
//   Clock in 1  : clock, posedge
//   Reset in 1  : synchronous active-high reset, highest priority
//   Start in 1  : load A/B and (re)start a division
//   A     in 16 : dividend
//   B     in 8  : divisor
//   Q     out 16: quotient (registered, held between results)
//   R     out 8 : remainder (registered, held between results)
//   Busy  out 1 : iterations in progress
//   Done  out 1 : one-cycle pulse when Q/R are fresh
//   Err   out 1 : divide-by-zero flag, valid with Done
module dbs
    import dbs_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [DVD_W-1:0] A,
    input  logic [DVS_W-1:0] B,
    output logic [DVD_W-1:0] Q,
    output logic [DVS_W-1:0] R,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    state_e             state_q, state_d;
    logic [DVD_W-1:0]   da_q, da_d;
    logic [DVS_W-1:0]   db_q, db_d;
    logic [DVS_W-1:0]   pr_q, pr_d;
    logic [DVD_W-1:0]   dq_q, dq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   quo_q, quo_d;
    logic [DVS_W-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef DBS_DIVZERO_EN
    logic               err_q, err_d;
    logic               dz_q, dz_d;
`endif

    logic [DVS_W-1:0]   step_pr;
    logic               step_q;

    dbs_step u_step (
        .pr      (pr_q),
        .da_msb  (da_q[DVD_W-1]),
        .db      (db_q),
        .pr_next (step_pr),
        .q       (step_q)
    );

    // Next-state and datapath; Start overrides the current state (abort/reload).
    always_comb begin
        state_d = state_q;
        da_d    = da_q;
        db_d    = db_q;
        pr_d    = pr_q;
        dq_d    = dq_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef DBS_DIVZERO_EN
        err_d   = err_q;
        dz_d    = dz_q;
`endif
        if (Start) begin
            state_d = S_RUN;
            da_d    = A;
            db_d    = B;
            pr_d    = '0;
            dq_d    = '0;
            cnt_d   = '0;
`ifdef DBS_DIVZERO_EN
            err_d   = 1'b0;
            dz_d    = (B == '0);
`endif
        end else begin
            case (state_q)
                S_RUN: begin
`ifdef DBS_DIVZERO_EN
                    if (dz_q) begin
                        // Dividend is still unshifted, so its low byte is A[7:0].
                        quo_d   = '1;
                        rem_d   = da_q[DVS_W-1:0];
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        dz_d    = 1'b0;
                        state_d = S_DONE;
                    end else begin
`endif
                        pr_d  = step_pr;
                        da_d  = da_q << 1;
                        dq_d  = {dq_q[DVD_W-2:0], step_q};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ITER - 1)) begin
                            quo_d   = {dq_q[DVD_W-2:0], step_q};
                            rem_d   = step_pr;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_DONE;
                        end
`ifdef DBS_DIVZERO_EN
                    end
`endif
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
`ifdef DBS_DIVZERO_EN
        busy_d = (state_d == S_RUN) && !dz_d;
`else
        busy_d = (state_d == S_RUN);
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            da_q    <= '0;
            db_q    <= '0;
            pr_q    <= '0;
            dq_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DBS_DIVZERO_EN
            err_q   <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            da_q    <= da_d;
            db_q    <= db_d;
            pr_q    <= pr_d;
            dq_q    <= dq_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DBS_DIVZERO_EN
            err_q   <= err_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign Q    = quo_q;
    assign R    = rem_q;
    assign Busy = busy_q;
    assign Done = done_q;
`ifdef DBS_DIVZERO_EN
    assign Err  = err_q;
`else
    assign Err  = 1'b0;
`endif

endmodule

// File: tb/tb_dbs.sv
// tb_dbs: self-checking bench for dbs, directed cases plus random operands
// compared against an arithmetic (/ and %) reference model.
module tb_dbs;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] A = '0;
    logic [7:0]  B = '0;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        Busy;
    logic        Done;
    logic        Err;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_q = '0;
    logic [7:0]  last_r = '0;

    dbs dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .Busy  (Busy),
        .Done  (Done),
        .Err   (Err)
    );

    always #5 Clock = ~Clock;

    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic e, output int lat, output int busy_n);
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = a[7:0];
`ifdef DBS_DIVZERO_EN
            e = 1'b1; lat = 1; busy_n = 0;
`else
            e = 1'b0; lat = 16; busy_n = 16;
`endif
        end else begin
            q = a / 16'(b);
            r = 8'(a % 16'(b));
            e = 1'b0; lat = 16; busy_n = 16;
        end
    endfunction

    // Called at a negedge: present operands for exactly one posedge.
    task automatic drive(input logic [15:0] a, input logic [7:0] b);
        Start = 1'b1; A = a; B = b;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called one negedge after the Start edge; returns at the negedge where Done is seen.
    task automatic wait_result(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ee;
        int          elat, ebusy;
        int          lat;
        int          busy_n;
        model(a, b, eq, er, ee, elat, ebusy);
        lat = 0;
        busy_n = 0;
        while (Done !== 1'b1 && lat < 40) begin
            if (Busy === 1'b1) busy_n++;
            check("hold_q", 32'(Q), 32'(last_q));
            check("hold_r", 32'(R), 32'(last_r));
            @(negedge Clock);
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("busy_cycles", 32'(busy_n), 32'(ebusy));
        check("busy_in_done", 32'(Busy), 32'(0));
        check("q", 32'(Q), 32'(eq));
        check("r", 32'(R), 32'(er));
        check("err", 32'(Err), 32'(ee));
        last_q = eq;
        last_r = er;
    endtask

    task automatic full_op(input logic [15:0] a, input logic [7:0] b);
        drive(a, b);
        wait_result(a, b);
        @(negedge Clock);
        check("done_drop", 32'(Done), 32'(0));
        check("q_hold_after", 32'(Q), 32'(last_q));
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;

        // Reset
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        check("rst_q", 32'(Q), 32'(0));
        check("rst_r", 32'(R), 32'(0));
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_done", 32'(Done), 32'(0));
        check("rst_err", 32'(Err), 32'(0));

        // Directed cases
        full_op(16'd1000, 8'd7);
        full_op(16'd65535, 8'd255);
        full_op(16'd5, 8'd9);
        full_op(16'h1234, 8'd0);
        full_op(16'd0, 8'd1);
        full_op(16'd65535, 8'd1);

        // Abort: restart at iteration 5 with new operands
        drive(16'd1000, 8'd7);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", 32'(Done), 32'(0));
            @(negedge Clock);
        end
        drive(16'd500, 8'd10);
        wait_result(16'd500, 8'd10);
        @(negedge Clock);
        check("abort_done_drop", 32'(Done), 32'(0));

        // Reset mid-RUN
        drive(16'd40000, 8'd3);
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("midrst_q", 32'(Q), 32'(0));
        check("midrst_r", 32'(R), 32'(0));
        check("midrst_busy", 32'(Busy), 32'(0));
        last_q = '0;
        last_r = '0;
        for (int i = 0; i < 20; i++) begin
            check("midrst_no_done", 32'(Done), 32'(0));
            @(negedge Clock);
        end

        // Reset and Start on the same edge: Reset wins
        Reset = 1'b1;
        drive(16'd77, 8'd5);
        Reset = 1'b0;
        check("rst_start_busy", 32'(Busy), 32'(0));
        repeat (20) begin
            check("rst_start_no_done", 32'(Done), 32'(0));
            @(negedge Clock);
        end

        // Back-to-back: second Start in the DONE cycle
        drive(16'd12345, 8'd100);
        wait_result(16'd12345, 8'd100);
        drive(16'd54321, 8'd77);
        wait_result(16'd54321, 8'd77);
        @(negedge Clock);
        check("b2b_done_drop", 32'(Done), 32'(0));

        // Random operands, divisor zero sometimes
        for (int n = 0; n < 30; n++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            full_op(ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
